// File: rtl/gpc231_4_bist_pkg.sv
// Shared types and helpers for the gpc231_4 built-in self-test sequencer.
package gpc_pkg;

   localparam int unsigned VEC_W   = 6;
   localparam int unsigned DST_W   = 4;
   localparam int unsigned NUM_VEC = 64;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;

   typedef struct packed {
      logic             valid;
      logic [VEC_W-1:0] vec;
      logic [DST_W-1:0] exp;
   } bist_tag_t;

   // Weighted sum of a test vector: bit0 weight 1, bits 3:1 weight 2, bits 5:4 weight 4.
   function automatic logic [DST_W-1:0] gpc231_weight(input logic [VEC_W-1:0] vec);
      logic [DST_W-1:0] s;
      s = {3'b000, vec[0]};
      for (int unsigned i = 1; i < 4; i++) s = s + {2'b00, vec[i], 1'b0};
      for (int unsigned i = 4; i < 6; i++) s = s + {1'b0, vec[i], 2'b00};
      return s;
   endfunction

endpackage

// File: rtl/gpc231_4_bist_if.sv
// GPC operand/result bundle; the BIST drives operands as master, the GPC answers as slave.
interface gpc231_4_bist_if;
   import gpc_pkg::*;

   logic             src0;
   logic [2:0]       src1;
   logic [1:0]       src2;
   logic [DST_W-1:0] dst;

   modport master (output src0, output src1, output src2, input dst);
   modport slave  (input src0, input src1, input src2, output dst);
endinterface

// File: rtl/gpc231_4_bist_delay.sv
// Fixed-depth delay line for compare tags; reset clears only the valid bits.
module gpc_bist_delay
   import gpc_pkg::*;
#(
   parameter int unsigned DEPTH = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  bist_tag_t tag_in,
   output bist_tag_t tag_out
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign tag_out = tag_in;
      end else begin : g_shift
         bist_tag_t stage_q [DEPTH];
         bist_tag_t stage_d [DEPTH];

         always_comb begin
            stage_d[0] = tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
         end

         always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               stage_q[i] <= stage_d[i];
               if (rst) stage_q[i].valid <= 1'b0;
            end
         end

         assign tag_out = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/gpc231_4_bist.sv
// Self-test sequencer: sweeps all 64 gpc231_4 inputs, compares dst against the
// weighted sum after DUT_LAT cycles and reports error count and first failure.
module gpc231_4_bist
   import gpc_pkg::*;
#(
   parameter int unsigned DUT_LAT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   gpc231_4_bist_if.master gpc,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [6:0]      err_count,
   output logic [5:0]      first_fail
);

   bist_state_t      state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [2:0]       drain_q, drain_d;
   logic [6:0]       err_q, err_d;
   logic [5:0]       ff_q, ff_d;
   logic             pass_q, pass_d;
   bist_tag_t        tag_in, tag_out;

   assign tag_in.valid = (state_q == RUN);
   assign tag_in.vec   = vec_q;
   assign tag_in.exp   = gpc231_weight(vec_q);

   gpc_bist_delay #(.DEPTH(DUT_LAT)) u_delay (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Compare first, then the FSM, so a start-clear overrides and pass sees the final count.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      drain_d = drain_q;
      err_d   = err_q;
      ff_d    = ff_q;
      pass_d  = pass_q;

      if (tag_out.valid && (gpc.dst != tag_out.exp)) begin
         err_d = err_q + 7'd1;
         if (err_q == 7'd0) ff_d = tag_out.vec;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               vec_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            vec_d = vec_q + 6'd1;
            if (vec_q == 6'(NUM_VEC - 1)) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            if (drain_q == 3'(DUT_LAT)) begin
               state_d = DONE;
               pass_d  = (err_d == 7'd0);
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         drain_q <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         drain_q <= drain_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         pass_q  <= pass_d;
      end
   end

   assign gpc.src0  = (state_q == RUN) ? vec_q[0]   : 1'b0;
   assign gpc.src1  = (state_q == RUN) ? vec_q[3:1] : '0;
   assign gpc.src2  = (state_q == RUN) ? vec_q[5:4] : '0;
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_gpc231_4_bist.sv
// Bench for gpc231_4_bist: two instances (DUT_LAT 0 and 2) against bench GPC models,
// a cycle-level expectation model and directed literal checks.
module tb_gpc231_4_bist;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0;
   logic start2 = 1'b0;
   always #5 clk = ~clk;

   gpc231_4_bist_if g0 ();
   gpc231_4_bist_if g2 ();

   logic       busy0, done0, pass0, busy2, done2, pass2;
   logic [6:0] errc0, errc2;
   logic [5:0] ffail0, ffail2;

   gpc231_4_bist #(.DUT_LAT(0)) u0 (
      .clk(clk), .rst(rst), .start(start0), .gpc(g0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0), .first_fail(ffail0)
   );

   gpc231_4_bist #(.DUT_LAT(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .gpc(g2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(errc2), .first_fail(ffail2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Bench GPC: mode 0 correct, 1 dst[0] stuck at 0, 2 wrong (0) at vector 0x2a.
   int mode0 = 0;
   bit pipe0 = 1'b0;

   function automatic logic [3:0] gpc_out(input int mode, input logic [5:0] v);
      int s;
      s = int'(v[0]) + 2 * $countones(v[3:1]) + 4 * $countones(v[5:4]);
      if (mode == 1) s = s & 14;
      if (mode == 2 && v == 6'h2a) s = 0;
      return 4'(s);
   endfunction

   logic [5:0] in0, in2;
   logic [3:0] p0a, p0b, p2a, p2b;
   assign in0 = {g0.src2, g0.src1, g0.src0};
   assign in2 = {g2.src2, g2.src1, g2.src0};

   always @(posedge clk) begin
      p0a <= gpc_out(mode0, in0);
      p0b <= p0a;
      p2a <= gpc_out(0, in2);
      p2b <= p2a;
   end

   assign g0.dst = pipe0 ? p0b : gpc_out(mode0, in0);
   assign g2.dst = p2b;

   // Expectation model: sweep start cycle per instance and which vectors must be flagged.
   int lat [2] = '{0, 2};
   bit act [2];
   int t0  [2];
   bit badv [2][64];

   function automatic int ref_sum(input int v);
      return (v & 1) + 2 * (((v >> 1) & 1) + ((v >> 2) & 1) + ((v >> 3) & 1))
             + 4 * (((v >> 4) & 1) + ((v >> 5) & 1));
   endfunction

   function automatic bit comp_bad(input int l, input int p, input int mode, input int k);
      int j, inp;
      j   = k + l - p;
      inp = (j >= 0 && j <= 63) ? j : 0;
      return int'(gpc_out(mode, 6'(inp))) != ref_sum(k);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit st, iod;
         st  = (i == 0) ? start0 : start2;
         iod = !act[i] || (cyc - t0[i] >= 66 + lat[i]);
         if (rst) act[i] = 1'b0;
         else if (st && iod) begin
            act[i] = 1'b1;
            t0[i]  = cyc;
            for (int k = 0; k < 64; k++)
               badv[i][k] = comp_bad(lat[i], (i == 0) ? (pipe0 ? 2 : 0) : 2,
                                     (i == 0) ? mode0 : 0, k);
         end
      end
      cyc = cyc + 1;
   end

   task automatic check(input string name, input int actual, input int expected);
      total = total + 1;
      if (actual != expected) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int s, l, eb, ed, ep, ev, ee, ef;
            l = lat[i];
            s = cyc - t0[i];
            eb = 0; ed = 0; ep = 0; ev = 0; ee = 0; ef = 0;
            if (act[i]) begin
               eb = (s >= 1 && s <= 65 + l) ? 1 : 0;
               ed = (s >= 66 + l) ? 1 : 0;
               ev = (s >= 1 && s <= 64) ? s - 1 : 0;
               for (int k = 0; k < 64; k++)
                  if (badv[i][k] && k + l + 2 <= s) begin
                     if (ee == 0) ef = k;
                     ee++;
                  end
               ep = (ed == 1 && ee == 0) ? 1 : 0;
            end
            check($sformatf("u%0d_busy", i), int'(i == 0 ? busy0 : busy2), eb);
            check($sformatf("u%0d_done", i), int'(i == 0 ? done0 : done2), ed);
            check($sformatf("u%0d_pass", i), int'(i == 0 ? pass0 : pass2), ep);
            check($sformatf("u%0d_src", i), int'(i == 0 ? in0 : in2), ev);
            check($sformatf("u%0d_err", i), int'(i == 0 ? errc0 : errc2), ee);
            check($sformatf("u%0d_ffail", i), int'(i == 0 ? ffail0 : ffail2), ef);
         end
      end
   end

   task automatic pulse_start(input bit s0, input bit s2);
      @(negedge clk);
      start0 = s0;
      start2 = s2;
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   // n counts the cycle index relative to the start edge; called in cycle T+n_in.
   task automatic wait_done(input int i, input int n_in, output int n);
      n = n_in;
      while (!((i == 0) ? done0 : done2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("u%0d_timeout", i), int'(n >= 200), 0);
   endtask

   initial begin
      int n0, n2, nw;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_err", int'(errc0), 0);
      check("rst_done", int'(done0), 0);

      // Correct GPCs: combinational on u0, two-stage on u2.
      pulse_start(1'b1, 1'b1);
      wait_done(0, 1, n0);
      wait_done(1, n0, n2);
      check("a_lat0_done_cycle", n0, 66);
      check("a_lat2_done_cycle", n2, 68);
      check("a_pass0", int'(pass0), 1);
      check("a_pass2", int'(pass2), 1);
      check("a_err0", int'(errc0), 0);

      mode0 = 1;
      pulse_start(1'b1, 1'b0);
      wait_done(0, 1, n0);
      check("b_err_stuck", int'(errc0), 32);
      check("b_ffail_stuck", int'(ffail0), 1);
      check("b_pass_stuck", int'(pass0), 0);

      mode0 = 2;
      pulse_start(1'b1, 1'b0);
      wait_done(0, 1, n0);
      check("c_err_2a", int'(errc0), 1);
      check("c_ffail_2a", int'(ffail0), 42);
      check("c_pass_2a", int'(pass0), 0);

      mode0 = 0;
      pipe0 = 1'b1;
      pulse_start(1'b1, 1'b0);
      wait_done(0, 1, n0);
      check("d_latmis_pass", int'(pass0), 0);
      check("d_latmis_err_nz", int'(errc0 != 7'd0), 1);

      // Abort mid-sweep with a one-cycle reset at vector 20, then sweep again.
      pipe0 = 1'b0;
      pulse_start(1'b1, 1'b0);
      nw = 0;
      while (in0 != 6'd20 && nw < 100) begin
         @(negedge clk);
         nw++;
      end
      check("e_reach_vec20", int'(nw >= 100), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("e_rst_busy", int'(busy0), 0);
      check("e_rst_src", int'(in0), 0);
      check("e_rst_err", int'(errc0), 0);
      pulse_start(1'b1, 1'b0);
      wait_done(0, 1, n0);
      check("e_done_cycle", n0, 66);
      check("e_pass", int'(pass0), 1);

      // start held through RUN/DRAIN, still high in DONE -> single restart.
      mode0 = 1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      wait_done(0, 1, n0);
      check("f_done_cycle", n0, 66);
      check("f_err", int'(errc0), 32);
      @(negedge clk);
      start0 = 1'b0;
      check("f_restart_done", int'(done0), 0);
      check("f_restart_busy", int'(busy0), 1);
      check("f_restart_err", int'(errc0), 0);
      check("f_restart_src", int'(in0), 0);
      wait_done(0, 1, n0);
      check("f2_done_cycle", n0, 66);
      check("f2_err", int'(errc0), 32);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
